pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic parametrised pipeline buffer register. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB
//  struct registers; each stage instantiates one with its own struct packed into ctrl and data fields.
//  Provides valid/ready handshake (stall), synchronous flush, NOP-bubble insertion on control bits and a
//  saturating stall counter. Sits between two adjacent core stages.
// PARAMETERS
//  CTRL_W   8    width of control field (RegWrite, MemRead, Jump, Halt...); forced to 0 in bubbles
//  DATA_W   64   width of payload field (PC, instr, operands, imm); held, not cleared, in bubbles
//  CNT_W    16   width of stall counter
// PORTS
//  clk        in   1       core clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous kill of held/incoming entries (branch/jump redirect)
//  in_valid   in   1       upstream stage presents an entry
//  in_ready   out  1       buffer accepts entry this cycle
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       entry presented downstream
//  out_ready  in   1       downstream consumes entry this cycle
//  out_ctrl   out  CTRL_W  control bits; all zero whenever out_valid=0
//  out_data   out  DATA_W  payload
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  - Reset (reset=0, async): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, all internal valid bits 0.
//  - Transfer in: in_valid & in_ready at clk edge. Transfer out: out_valid & out_ready at clk edge.
//  - Base (single entry): in_ready = ~out_valid | out_ready (combinational).
//    Latency = 1 cycle; back-to-back throughput of 1 entry/cycle when out_ready=1.
//  - Load: on in-transfer, out_ctrl<=in_ctrl, out_data<=in_data, out_valid<=1.
//    Out-transfer without in-transfer: out_valid<=0, out_ctrl<=0, out_data held.
//  - Stall: out_valid=1 & out_ready=0 -> all outputs held bit-exact, in_ready=0.
//  - Flush (highest priority, sync): next cycle out_valid=0, out_ctrl=0; any in_valid this cycle is
//    discarded (in_ready may read 1, but no entry is loaded). Flush with the buffer already empty is a no-op.
//  - Simultaneous out-transfer and in-transfer: new entry replaces old in the same edge, out_valid stays 1.
//  - Halt is carried as an ordinary ctrl bit; the block never interprets ctrl.
//  - stall_cnt: +1 on each cycle out_valid & ~out_ready; saturates at 2^CNT_W-1; cleared only by reset.
//  - Reset asserted mid-stall: entries are lost and outputs return to reset values immediately.
// CONFIGURATION
//  PIPE_SKID_EN defined: adds a second (skid) entry so in_ready is a pure flop output, breaking the
//    combinational ready path across stages. in_ready = ~skid_valid (registered).
//    If the main entry is stalled and an entry is accepted, it goes to the skid entry.
//    When the main entry drains, skid moves to main in the same edge; order is preserved.
//    Flush clears both entries. Max occupancy is 2.
//  PIPE_SKID_EN undefined: single entry, combinational in_ready as above.
// TESTING
//  1 reset=0 while in_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0; after release, first load
//    occurs at 1st edge.
//  2 stream ctrl=8'h5A, data=64'h1..4 with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles,
//    1-cycle latency.
//  3 load data=64'hAA, hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 (base), stall_cnt=5.
//  4 flush=1 with out_valid=1 and in_valid=1 (ctrl=8'hFF) -> next cycle out_valid=0, out_ctrl=8'h00,
//    0xFF entry never appears.
//  5 CNT_W=4, stall 20 cycles -> stall_cnt saturates at 15.
//  6 PIPE_SKID_EN: out_ready=0, send A,B -> both accepted, then in_ready=0; out_ready=1 -> A then B,
//    no loss or duplication.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, flush, ctrl bubbling and stall counter.
// Optional skid entry (registered in_ready) enabled by defining PIPE_SKID_EN.
module pipe_stage_buf #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic in_xfer;
  logic stalled;

  // Entries offered during a flush are dropped even if in_ready reads 1.
  assign in_xfer = in_valid & in_ready & ~flush;
  assign stalled = out_valid & ~out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = ~skid_valid;

  // Main entry refills from skid first so ordering is preserved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (!stalled) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else if (out_valid) begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  // Single entry: load on accept, bubble ctrl on drain, hold everything on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end
`endif

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (4-bit stall counter to reach saturation quickly).
module tb_pipe_stage_buf;

  localparam int unsigned CTRL_W = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h33;
    in_data   = 64'h77;
    out_ready = 1'b1;

    // Reset held with a pending entry
    repeat (3) step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_data",  out_data,       64'd0);
    check("rst_cnt",   64'(stall_cnt), 64'd0);

    // Release away from the edge, then stream 1..4
    #2;
    reset   = 1'b1;
    in_ctrl = 8'h5A;
    in_data = 64'h1;
    step();
    check("load1_valid", 64'(out_valid), 64'd1);
    check("load1_ctrl",  64'(out_ctrl),  64'h5A);
    check("load1_data",  out_data,       64'h1);
    for (int i = 2; i <= 4; i++) begin
      in_data = 64'(i);
      step();
      check("stream_data",  out_data,       64'(i));
      check("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_ctrl",  64'(out_ctrl),  64'd0);
    check("drain_data",  out_data,       64'h4);
    check("drain_cnt",   64'(stall_cnt), 64'd0);

    // Flush on an empty buffer changes nothing
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_empty_valid", 64'(out_valid), 64'd0);

    // Load 0xAA then stall 5 cycles
    in_valid  = 1'b1;
    in_ctrl   = 8'h3C;
    in_data   = 64'hAA;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
`ifndef PIPE_SKID_EN
    check("stall_in_ready", 64'(in_ready), 64'd0);
`endif
    repeat (5) begin
      step();
      check("stall_data", out_data,      64'hAA);
      check("stall_ctrl", 64'(out_ctrl), 64'h3C);
    end
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_cnt5",  64'(stall_cnt), 64'd5);

    // Flush with a held entry and an incoming 0xFF entry
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 8'hFF;
    in_data  = 64'hFF;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl",  64'(out_ctrl),  64'd0);
    check("flush_cnt",   64'(stall_cnt), 64'd6);
    step();
    check("flush_novalid", 64'(out_valid), 64'd0);
    check("flush_data",    out_data,       64'hAA);

    // Long stall saturates the counter
    in_valid = 1'b1;
    in_ctrl  = 8'h01;
    in_data  = 64'h5;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("sat_cnt",  64'(stall_cnt), 64'd15);
    check("sat_data", out_data,       64'h5);

    // Asynchronous reset in the middle of a stall
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ctrl",  64'(out_ctrl),  64'd0);
    check("arst_data",  out_data,       64'd0);
    check("arst_cnt",   64'(stall_cnt), 64'd0);
    #2;
    reset = 1'b1;

    // Simultaneous drain and load keeps out_valid high with the new entry
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h11;
    in_data   = 64'hC1;
    step();
    in_ctrl = 8'h22;
    in_data = 64'hC2;
    step();
    in_valid = 1'b0;
    check("swap_valid", 64'(out_valid), 64'd1);
    check("swap_ctrl",  64'(out_ctrl),  64'h22);
    check("swap_data",  out_data,       64'hC2);
    step();
    check("swap_drain", 64'(out_valid), 64'd0);

`ifdef PIPE_SKID_EN
    // Skid: accept A and B while stalled, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h0A;
    in_data   = 64'hA1;
    step();
    check("skid_a_data", out_data,      64'hA1);
    check("skid_rdy1",   64'(in_ready), 64'd1);
    in_ctrl = 8'h0B;
    in_data = 64'hB2;
    step();
    in_valid = 1'b0;
    check("skid_rdy0",   64'(in_ready), 64'd0);
    check("skid_hold_a", out_data,      64'hA1);
    out_ready = 1'b1;
    step();
    check("skid_b_valid", 64'(out_valid), 64'd1);
    check("skid_b_ctrl",  64'(out_ctrl),  64'h0B);
    check("skid_b_data",  out_data,       64'hB2);
    check("skid_rdy_back", 64'(in_ready), 64'd1);
    step();
    check("skid_empty", 64'(out_valid), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
